// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction fetch sequencer. It sits between the program counter block, the
// instruction memory and the decode stage. The sequencer runs through the
// following cycle:
//   1. Issue a read at the current PC.
//   2. Check odd parity on the returned word.
//   3. Present the 15-bit instruction on a valid/ready handshake.
//   4. Strobe the PC to either increment or jump.
//
// A flush from execute redirects the fetch stream. A read that is already
// outstanding cannot be aborted, so its data is discarded when it returns.
// A parity error halts the sequencer until the next reset.
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   pc_addr        in   12  current PC value
//   pc_enable      out      one-cycle PC advance strobe
//   pc_jump_select out      with pc_enable: 1 = load pc_jump_addr, 0 = increment
//   pc_jump_addr   out  12  jump target (zero outside the advance cycle)
//   mem_req        out      read request, held until mem_ack
//   mem_addr       out  12  read address (pc_addr while mem_req)
//   mem_ack        in       read data valid
//   mem_rdata      in   16  read word, bit 15 parity, bits 14:0 instruction
//   instr          out  15  fetched instruction
//   instr_valid    out      instruction available
//   instr_ready    in       downstream accepts instruction
//   flush          in       single-cycle redirect request
//   flush_addr     in   12  redirect target
//   parity_err     out      sticky parity error
// -----------------------------------------------------------------------------
module fetch_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] pc_addr,
    output logic        pc_enable,
    output logic        pc_jump_select,
    output logic [11:0] pc_jump_addr,
    output logic        mem_req,
    output logic [11:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [14:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        flush,
    input  logic [11:0] flush_addr,
    output logic        parity_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_HOLD    = 3'd2,
        S_ADVANCE = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [14:0] instr_reg, instr_next;
    logic        jump_sel_reg, jump_sel_next;
    logic [11:0] jump_addr_reg, jump_addr_next;
    logic        parity_err_reg, parity_err_next;
    logic        pend_reg, pend_next;
    logic [11:0] pend_addr_reg, pend_addr_next;

    // XOR reduction of the read word.
    // A set final bit means the popcount is odd, which is the valid case.
    logic [16:0] par_chain;
    logic        rdata_odd;

    assign par_chain[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_parity
            assign par_chain[gi+1] = par_chain[gi] ^ mem_rdata[gi];
        end
    endgenerate
    assign rdata_odd = par_chain[16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            instr_reg      <= '0;
            jump_sel_reg   <= 1'b0;
            jump_addr_reg  <= '0;
            parity_err_reg <= 1'b0;
            pend_reg       <= 1'b0;
            pend_addr_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            instr_reg      <= instr_next;
            jump_sel_reg   <= jump_sel_next;
            jump_addr_reg  <= jump_addr_next;
            parity_err_reg <= parity_err_next;
            pend_reg       <= pend_next;
            pend_addr_reg  <= pend_addr_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        instr_next      = instr_reg;
        jump_sel_next   = jump_sel_reg;
        jump_addr_next  = jump_addr_reg;
        parity_err_next = parity_err_reg;
        pend_next       = pend_reg;
        pend_addr_next  = pend_addr_reg;

        case (state_reg)
            S_IDLE: begin
                if (flush) begin
                    pend_next      = 1'b1;
                    pend_addr_next = flush_addr;
                end
                state_next = S_FETCH;
            end

            S_FETCH: begin
                if (mem_ack) begin
                    if (pend_reg || flush) begin
                        // The redirected read returns no usable data.
                        // A flush arriving in the same cycle as the ack wins
                        // over the older pending target.
                        jump_sel_next  = 1'b1;
                        jump_addr_next = flush ? flush_addr : pend_addr_reg;
                        pend_next      = 1'b0;
                        state_next     = S_ADVANCE;
                    end else if (rdata_odd) begin
                        instr_next = mem_rdata[14:0];
                        state_next = S_HOLD;
                    end else begin
                        parity_err_next = 1'b1;
                        state_next      = S_HALT;
                    end
                end else if (flush) begin
                    pend_next      = 1'b1;
                    pend_addr_next = flush_addr;
                end
            end

            S_HOLD: begin
                if (flush) begin
                    // A flush overrides a simultaneous ready.
                    // The held instruction counts as not consumed.
                    jump_sel_next  = 1'b1;
                    jump_addr_next = flush_addr;
                    state_next     = S_ADVANCE;
                end else if (instr_ready) begin
                    if (instr_reg[14:12] == 3'b000) begin
                        jump_sel_next  = 1'b1;
                        jump_addr_next = instr_reg[11:0];
                    end else begin
                        jump_sel_next = 1'b0;
                    end
                    state_next = S_ADVANCE;
                end
            end

            S_ADVANCE: begin
                if (flush) begin
                    pend_next      = 1'b1;
                    pend_addr_next = flush_addr;
                end
                state_next = S_FETCH;
            end

            S_HALT: begin
                state_next = S_HALT;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // All strobes decode directly from the state register.
    // This keeps the strobes glitch-free.
    // It also lets the asynchronous reset drop them immediately.
    assign mem_req        = (state_reg == S_FETCH);
    assign mem_addr       = mem_req ? pc_addr : 12'h000;
    assign instr_valid    = (state_reg == S_HOLD);
    assign pc_enable      = (state_reg == S_ADVANCE);
    assign pc_jump_select = pc_enable & jump_sel_reg;
    assign pc_jump_addr   = pc_enable ? jump_addr_reg : 12'h000;
    assign instr          = instr_reg;
    assign parity_err     = parity_err_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed bench for fetch_sequencer.
//
// A small behavioural PC block feeds pc_addr back to the sequencer. The PC
// register itself is reset asynchronously. On every clock edge where
// pc_enable is high, the PC either increments or loads the jump target.
//
// Memory responses are driven cycle by cycle from each scenario task.
// Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] pc_addr;
    logic        pc_enable;
    logic        pc_jump_select;
    logic [11:0] pc_jump_addr;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic [14:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        flush = 1'b0;
    logic [11:0] flush_addr = 12'h000;
    logic        parity_err;

    int checks = 0;
    int errors = 0;

    fetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_addr        (pc_addr),
        .pc_enable      (pc_enable),
        .pc_jump_select (pc_jump_select),
        .pc_jump_addr   (pc_jump_addr),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .flush          (flush),
        .flush_addr     (flush_addr),
        .parity_err     (parity_err)
    );

    always #5 clk = ~clk;

    // Behavioural model of the external program counter.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_addr <= 12'h000;
        else if (pc_enable)
            pc_addr <= pc_jump_select ? pc_jump_addr : pc_addr + 12'd1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++;
        if ({mem_req, pc_enable, pc_jump_select, instr_valid, parity_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b expected 00000",
                     {mem_req, pc_enable, pc_jump_select, instr_valid, parity_err});
        end
        checks++;
        if ({instr, mem_addr, pc_jump_addr} !== 39'h0) begin
            errors++;
            $display("FAIL reset_buses got instr=%h mem_addr=%h jump_addr=%h expected 0",
                     instr, mem_addr, pc_jump_addr);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_req got %b expected 0", mem_req);
        end
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 12'h000) begin
            errors++;
            $display("FAIL reset_first_fetch got req=%b addr=%h expected 1/000", mem_req, mem_addr);
        end
        $display("test_reset done");
    endtask

    task automatic test_increment();
        mem_ack = 1'b1;
        mem_rdata = 16'h1234;
        step();
        mem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr !== 15'h1234 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL inc_hold got valid=%b instr=%h req=%b expected 1/1234/0",
                     instr_valid, instr, mem_req);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        checks++;
        if (pc_enable !== 1'b1 || pc_jump_select !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL inc_advance got en=%b sel=%b valid=%b expected 1/0/0",
                     pc_enable, pc_jump_select, instr_valid);
        end
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 12'h001 || pc_enable !== 1'b0) begin
            errors++;
            $display("FAIL inc_next_fetch got req=%b addr=%h en=%b expected 1/001/0",
                     mem_req, mem_addr, pc_enable);
        end
        $display("test_increment done");
    endtask

    task automatic test_tc_jump();
        mem_ack = 1'b1;
        mem_rdata = 16'h80AA;
        step();
        mem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr !== 15'h00AA) begin
            errors++;
            $display("FAIL tc_hold got valid=%b instr=%h expected 1/00aa", instr_valid, instr);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        checks++;
        if (pc_enable !== 1'b1 || pc_jump_select !== 1'b1 || pc_jump_addr !== 12'h0AA) begin
            errors++;
            $display("FAIL tc_advance got en=%b sel=%b addr=%h expected 1/1/0aa",
                     pc_enable, pc_jump_select, pc_jump_addr);
        end
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 12'h0AA) begin
            errors++;
            $display("FAIL tc_next_fetch got req=%b addr=%h expected 1/0aa", mem_req, mem_addr);
        end
        $display("test_tc_jump done");
    endtask

    task automatic test_ready_stall_flush();
        mem_ack = 1'b1;
        mem_rdata = 16'h2003;
        step();
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr !== 15'h2003 || pc_enable !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_%0d got valid=%b instr=%h en=%b expected 1/2003/0",
                         i, instr_valid, instr, pc_enable);
            end
            step();
        end
        flush = 1'b1;
        flush_addr = 12'h155;
        instr_ready = 1'b1;
        step();
        flush = 1'b0;
        instr_ready = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || pc_enable !== 1'b1 || pc_jump_select !== 1'b1
            || pc_jump_addr !== 12'h155) begin
            errors++;
            $display("FAIL stall_flush got valid=%b en=%b sel=%b addr=%h expected 0/1/1/155",
                     instr_valid, pc_enable, pc_jump_select, pc_jump_addr);
        end
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 12'h155) begin
            errors++;
            $display("FAIL stall_next_fetch got req=%b addr=%h expected 1/155", mem_req, mem_addr);
        end
        $display("test_ready_stall_flush done");
    endtask

    task automatic test_flush_wait();
        // Wait cycle 1.
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL fw_wait1 got req=%b expected 1", mem_req);
        end
        step();
        // Wait cycle 2: the flush arrives here.
        flush = 1'b1;
        flush_addr = 12'h300;
        step();
        flush = 1'b0;
        // Wait cycle 3: the request must still be held.
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 12'h155 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL fw_wait3 got req=%b addr=%h valid=%b expected 1/155/0",
                     mem_req, mem_addr, instr_valid);
        end
        step();
        // Ack cycle. The data has bad parity, but it must be discarded unchecked.
        mem_ack = 1'b1;
        mem_rdata = 16'h1235;
        step();
        mem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || pc_enable !== 1'b1 || pc_jump_select !== 1'b1
            || pc_jump_addr !== 12'h300) begin
            errors++;
            $display("FAIL fw_advance got valid=%b en=%b sel=%b addr=%h expected 0/1/1/300",
                     instr_valid, pc_enable, pc_jump_select, pc_jump_addr);
        end
        checks++;
        if (parity_err !== 1'b0 || instr !== 15'h2003) begin
            errors++;
            $display("FAIL fw_discard got perr=%b instr=%h expected 0/2003", parity_err, instr);
        end
        step();
        checks++;
        if (mem_addr !== 12'h300) begin
            errors++;
            $display("FAIL fw_next_fetch got addr=%h expected 300", mem_addr);
        end
        $display("test_flush_wait done");
    endtask

    task automatic test_flush_with_ack();
        mem_ack = 1'b1;
        mem_rdata = 16'h1234;
        flush = 1'b1;
        flush_addr = 12'h0F0;
        step();
        mem_ack = 1'b0;
        flush = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || pc_enable !== 1'b1 || pc_jump_select !== 1'b1
            || pc_jump_addr !== 12'h0F0) begin
            errors++;
            $display("FAIL fa_advance got valid=%b en=%b sel=%b addr=%h expected 0/1/1/0f0",
                     instr_valid, pc_enable, pc_jump_select, pc_jump_addr);
        end
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 12'h0F0) begin
            errors++;
            $display("FAIL fa_next_fetch got req=%b addr=%h expected 1/0f0", mem_req, mem_addr);
        end
        $display("test_flush_with_ack done");
    endtask

    task automatic test_flush_in_advance();
        mem_ack = 1'b1;
        mem_rdata = 16'h1234;
        step();
        mem_ack = 1'b0;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        // ADVANCE increments the PC. The flush arriving here becomes pending.
        flush = 1'b1;
        flush_addr = 12'h222;
        step();
        flush = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 12'h0F1) begin
            errors++;
            $display("FAIL fadv_fetch got req=%b addr=%h expected 1/0f1", mem_req, mem_addr);
        end
        // A second flush while the first is still pending: the last one wins.
        flush = 1'b1;
        flush_addr = 12'h333;
        step();
        flush = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 16'h3001;
        step();
        mem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || pc_enable !== 1'b1 || pc_jump_select !== 1'b1
            || pc_jump_addr !== 12'h333) begin
            errors++;
            $display("FAIL fadv_lastwins got valid=%b en=%b sel=%b addr=%h expected 0/1/1/333",
                     instr_valid, pc_enable, pc_jump_select, pc_jump_addr);
        end
        step();
        checks++;
        if (mem_addr !== 12'h333 || instr !== 15'h1234) begin
            errors++;
            $display("FAIL fadv_next_fetch got addr=%h instr=%h expected 333/1234", mem_addr, instr);
        end
        $display("test_flush_in_advance done");
    endtask

    task automatic test_parity_halt();
        mem_ack = 1'b1;
        mem_rdata = 16'h1235;
        step();
        mem_ack = 1'b0;
        checks++;
        if (parity_err !== 1'b1 || instr_valid !== 1'b0 || mem_req !== 1'b0
            || instr !== 15'h1234) begin
            errors++;
            $display("FAIL halt_entry got perr=%b valid=%b req=%b instr=%h expected 1/0/0/1234",
                     parity_err, instr_valid, mem_req, instr);
        end
        flush = 1'b1;
        flush_addr = 12'h111;
        step();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mem_req !== 1'b0 || pc_enable !== 1'b0 || parity_err !== 1'b1) begin
                errors++;
                $display("FAIL halt_stay_%0d got req=%b en=%b perr=%b expected 0/0/1",
                         i, mem_req, pc_enable, parity_err);
            end
            step();
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (parity_err !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset_clear got perr=%b expected 0", parity_err);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 12'h000) begin
            errors++;
            $display("FAIL halt_restart got req=%b addr=%h expected 1/000", mem_req, mem_addr);
        end
        $display("test_parity_halt done");
    endtask

    task automatic test_reset_mid_request();
        // Wait one cycle in FETCH with no ack.
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 12'h000 || instr !== 15'h0) begin
            errors++;
            $display("FAIL midrst_async got req=%b addr=%h instr=%h expected 0/000/0000",
                     mem_req, mem_addr, instr);
        end
        // An ack arriving while reset is asserted must be ignored.
        mem_ack = 1'b1;
        mem_rdata = 16'h1234;
        step();
        mem_ack = 1'b0;
        rst_n = 1'b1;
        checks++;
        if (instr_valid !== 1'b0 || instr !== 15'h0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle got valid=%b instr=%h req=%b expected 0/0000/0",
                     instr_valid, instr, mem_req);
        end
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 12'h000) begin
            errors++;
            $display("FAIL midrst_fetch got req=%b addr=%h expected 1/000", mem_req, mem_addr);
        end
        $display("test_reset_mid_request done");
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3];
        words[0] = 16'h1234;
        words[1] = 16'h3001;
        words[2] = 16'h7000;
        for (int k = 0; k < 3; k++) begin
            mem_ack = 1'b1;
            mem_rdata = words[k];
            step();
            mem_ack = 1'b0;
            checks++;
            if (instr_valid !== 1'b1 || instr !== words[k][14:0]) begin
                errors++;
                $display("FAIL b2b_hold_%0d got valid=%b instr=%h expected 1/%h",
                         k, instr_valid, instr, words[k][14:0]);
            end
            instr_ready = 1'b1;
            step();
            instr_ready = 1'b0;
            checks++;
            if (pc_enable !== 1'b1 || pc_jump_select !== 1'b0) begin
                errors++;
                $display("FAIL b2b_adv_%0d got en=%b sel=%b expected 1/0",
                         k, pc_enable, pc_jump_select);
            end
            step();
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 12'(k + 1)) begin
                errors++;
                $display("FAIL b2b_fetch_%0d got req=%b addr=%h expected 1/%h",
                         k, mem_req, mem_addr, 12'(k + 1));
            end
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_increment();
        test_tc_jump();
        test_ready_stall_flush();
        test_flush_wait();
        test_flush_with_ack();
        test_flush_in_advance();
        test_parity_halt();
        test_reset_mid_request();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch sequencer that drives the program counter and reads instruction words from fixed memory. Each cycle of its state machine issues a memory read at the current PC address and checks odd parity on the returned 16-bit word. It then hands the 15-bit instruction downstream over a valid/ready handshake and commands the PC to increment or jump. It sits between the `pc` block (driving its `enable`/`jumpSelect`/`jumpAddr` inputs and consuming `PCaddr`) and the memory and decode stages.

## Interface
- No parameters; widths fixed: address 12 bits, memory word 16 bits (bit 15 parity, bits 14:0 data), opcode = data[14:12].
- `clk` in 1 — system clock, all state updates on rising edge.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `pc_addr` in 12 — current PC value from the `pc` block.
- `pc_enable` out 1 — one-cycle strobe advancing the PC.
- `pc_jump_select` out 1 — with `pc_enable`: 1 = load `pc_jump_addr`, 0 = increment.
- `pc_jump_addr` out 12 — jump target.
- `mem_req` out 1 — read request, held until `mem_ack`.
- `mem_addr` out 12 — read address, equals `pc_addr` while `mem_req`=1.
- `mem_ack` in 1 — read data valid this cycle; only sampled while `mem_req`=1.
- `mem_rdata` in 16 — read word.
- `instr` out 15 — fetched instruction, stable while `instr_valid`=1.
- `instr_valid` out 1 — instruction available.
- `instr_ready` in 1 — downstream accepts instruction when `instr_valid`=1.
- `flush` in 1 — single-cycle redirect request from execute.
- `flush_addr` in 12 — redirect target, sampled when `flush`=1.
- `parity_err` out 1 — sticky fetch parity error, cleared only by reset.

## Operation
- States: IDLE, FETCH, HOLD, ADVANCE, HALT. Reset (async) → IDLE; all outputs 0, `instr` 0, flush-pending flag 0.
- IDLE: no outputs active; → FETCH next cycle.
- FETCH: `mem_req`=1, `mem_addr`=`pc_addr`. On `mem_ack`:
  - Flush pending: discard the data with no parity check. Set `pc_jump_addr`←pending target and clear pending. → ADVANCE with jump.
  - Popcount of `mem_rdata[15:0]` odd: `instr`←`mem_rdata[14:0]`. → HOLD.
  - Popcount even: `parity_err`←1. → HALT.
- HOLD: `instr_valid`=1. On `instr_ready`=1 (no flush this cycle), go to ADVANCE:
  - If `instr[14:12]`=3'b000 (TC), set `pc_jump_select`=1 and `pc_jump_addr`=`instr[11:0]`.
  - Otherwise set `pc_jump_select`=0.
- ADVANCE: `pc_enable`=1 for exactly one cycle with the registered `pc_jump_select`/`pc_jump_addr`. → FETCH.
- HALT: all strobes 0, `parity_err`=1. Stays until reset; `flush` is ignored.
- Flush, by state:
  - FETCH: the memory request cannot be aborted. Latch `flush_addr` as pending; the outstanding ack is absorbed and discarded. A flush in the same cycle as `mem_ack` is treated as already pending for that ack.
  - HOLD: drop `instr_valid` next cycle. Flush beats a simultaneous `instr_ready`; the instruction counts as not consumed. → ADVANCE with jump to `flush_addr`.
  - ADVANCE or IDLE: latch as pending. The next FETCH runs to ack, discards the data, and jumps.
  - A later flush overwrites the pending target; last wins.
- `pc_jump_select` and `pc_jump_addr` are meaningful only while `pc_enable`=1; otherwise `pc_jump_select`=0.

## Timing
- `pc_enable` is registered. The PC updates on the edge ending ADVANCE, so the following FETCH sees the new `pc_addr`.
- Zero-wait memory (ack in the first FETCH cycle) plus immediate ready gives 3 cycles per instruction: FETCH, HOLD, ADVANCE.
- Each memory wait cycle adds 1 cycle; each cycle of ready held low in HOLD adds 1 cycle.
- `instr_valid` rises the cycle after the accepting ack. `instr` never changes while `instr_valid`=1.
- Reset asserted mid-request drops `mem_req` immediately (async). An ack arriving during reset is ignored.
- PC wrap (0xFFF→0x000) is owned by `pc`; the sequencer is address-agnostic.

## Test plan
- Reset, PC=0x000, mem[0]=0x1234, ack same cycle, ready=1 → `instr`=0x1234 valid in cycle 2; `pc_enable`=1 with `pc_jump_select`=0 in cycle 3; PC=0x001 in cycle 4 and next `mem_addr`=0x001.
- mem[0]=0x80AA (TC 0x0AA, parity ok) → `pc_enable` with `pc_jump_select`=1, `pc_jump_addr`=0x0AA; next FETCH `mem_addr`=0x0AA.
- mem[0]=0x1235 (even popcount) → `parity_err`=1 and `instr_valid`=0. No further `mem_req` or `pc_enable` until `rst_n` pulses low; a flush in the meantime is ignored.
- Ack delayed 3 cycles; `flush`=1 with `flush_addr`=0x300 in the 2nd wait cycle → `mem_req` held until ack, data discarded (`instr_valid` never rises), jump to 0x300.
- `instr_ready`=0 for 4 cycles, then `flush` (0x155) and `instr_ready` together → `instr` stable through HOLD, no increment, jump to 0x155.
- `rst_n` low during WAIT with `mem_req`=1 → all outputs 0 immediately; after release, IDLE for one cycle, then FETCH.
